// File: rtl/alu_issue_stage_pkg.sv
// Shared constants for the ALU issue stage: ALU_control codes, ALUOp
// encodings and the R-type funct values understood by the decoder.
package alu_issue_stage_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd6,
    ALU_SLT = 3'd7
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } aluop_e;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/alu_issue_stage_if.sv
// ID -> EX issue bus: decoded instruction fields plus the valid/ready/flush
// handshake. The ID stage is the master, the issue stage the slave.
interface alu_issue_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          id_valid;
  logic          id_ready;
  logic          flush;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic [DW-1:0] id_rdata1;
  logic [DW-1:0] id_rdata2;
  logic [DW-1:0] id_imm;
  logic          id_alusrc;
  logic          id_regdst;
  logic [1:0]    id_aluop;
  logic [5:0]    id_funct;
  logic          id_memread;
  logic          id_regwrite;

  modport master (
    output id_valid, flush, id_rs, id_rt, id_rd, id_rdata1, id_rdata2,
           id_imm, id_alusrc, id_regdst, id_aluop, id_funct, id_memread,
           id_regwrite,
    input  id_ready
  );

  modport slave (
    input  id_valid, flush, id_rs, id_rt, id_rd, id_rdata1, id_rdata2,
           id_imm, id_alusrc, id_regdst, id_aluop, id_funct, id_memread,
           id_regwrite,
    output id_ready
  );
endinterface

// File: rtl/alu_issue_stage_alu_ctrl_dec.sv
// Combinational ALUOp/funct to ALU_control decoder with an illegal flag
// for R-type funct values the ALU does not implement.
module alu_ctrl_dec
  import alu_issue_stage_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output alu_ctrl_e  ctrl_o,
  output logic       illegal_o
);

  // Main decode on ALUOp, secondary decode on funct for R-type
  always_comb begin
    ctrl_o    = ALU_ADD;
    illegal_o = 1'b0;
    case (aluop_i)
      ALUOP_ADD: ctrl_o = ALU_ADD;
      ALUOP_SUB: ctrl_o = ALU_SUB;
      ALUOP_OR:  ctrl_o = ALU_OR;
      default: begin
        case (funct_i)
          FN_ADD:  ctrl_o = ALU_ADD;
          FN_SUB:  ctrl_o = ALU_SUB;
          FN_AND:  ctrl_o = ALU_AND;
          FN_OR:   ctrl_o = ALU_OR;
          FN_SLT:  ctrl_o = ALU_SLT;
          default: begin
            ctrl_o    = ALU_ADD;
            illegal_o = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register and issue logic feeding the EX-stage ALU.
// Optional macro ALU_FWD_EN: when defined, operands are forwarded from
// EX/MEM and MEM/WB; when undefined, forwarding is replaced by stalling on
// any producer still in EX or EX/MEM.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_stage_if.slave id,
  input  logic             exm_regwrite,
  input  logic [RW-1:0]    exm_rd,
  input  logic [DW-1:0]    exm_result,
  input  logic             wb_regwrite,
  input  logic [RW-1:0]    wb_rd,
  input  logic [DW-1:0]    wb_result,
  output logic             ex_valid,
  output logic [DW-1:0]    Read_data_1,
  output logic [DW-1:0]    Data_2,
  output logic [2:0]       ALU_control,
  output logic [RW-1:0]    ex_dest,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             ex_valid_q,    ex_valid_d;
  logic             ex_regwrite_q, ex_regwrite_d;
  logic             ex_memread_q,  ex_memread_d;
  logic             illegal_q,     illegal_d;
  logic [RW-1:0]    ex_dest_q,     ex_dest_d;
  logic [CNT_W-1:0] stall_cnt_q,   stall_cnt_d;
  alu_ctrl_e        alu_ctrl_q,    alu_ctrl_d;
  logic [RW-1:0]    rs_q,          rs_d;
  logic [RW-1:0]    rt_q,          rt_d;
  logic [DW-1:0]    rdata1_q,      rdata1_d;
  logic [DW-1:0]    rdata2_q,      rdata2_d;
  logic [DW-1:0]    imm_q,         imm_d;
  logic             alusrc_q,      alusrc_d;

  alu_ctrl_e        dec_ctrl;
  logic             dec_illegal;
  logic             hz;
  logic             ld_hz;
  logic [DW-1:0]    opa;
  logic [DW-1:0]    opb;

  alu_ctrl_dec u_dec (
    .aluop_i   (id.id_aluop),
    .funct_i   (id.id_funct),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

  // Load-use: the load in EX cannot supply its data before the next cycle
  assign ld_hz = ex_valid_q && ex_memread_q && (ex_dest_q != '0) &&
                 ((ex_dest_q == id.id_rs) || (ex_dest_q == id.id_rt));

`ifdef ALU_FWD_EN
  assign hz = ld_hz;

  // Operand forwarding; EX/MEM is younger so it wins over MEM/WB
  always_comb begin
    opa = rdata1_q;
    opb = rdata2_q;
    if (exm_regwrite && (exm_rd != '0) && (exm_rd == rs_q))
      opa = exm_result;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs_q))
      opa = wb_result;
    if (exm_regwrite && (exm_rd != '0) && (exm_rd == rt_q))
      opb = exm_result;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rt_q))
      opb = wb_result;
  end
`else
  logic ex_hz;
  logic exm_hz;
  logic unused_nofwd;

  // Without forwarding, wait until any pending producer has left EX/MEM
  assign ex_hz  = ex_valid_q && ex_regwrite_q && (ex_dest_q != '0) &&
                  ((ex_dest_q == id.id_rs) || (ex_dest_q == id.id_rt));
  assign exm_hz = exm_regwrite && (exm_rd != '0) &&
                  ((exm_rd == id.id_rs) || (exm_rd == id.id_rt));
  assign hz     = ld_hz || ex_hz || exm_hz;

  assign opa          = rdata1_q;
  assign opb          = rdata2_q;
  assign unused_nofwd = ^{exm_result, wb_regwrite, wb_rd, wb_result, rs_q, rt_q};
`endif

  assign id.id_ready = !hz;

  // Next-state: bubble on flush or hazard, otherwise latch the ID fields
  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_regwrite_d = ex_regwrite_q;
    ex_memread_d  = ex_memread_q;
    illegal_d     = illegal_q;
    ex_dest_d     = ex_dest_q;
    stall_cnt_d   = stall_cnt_q;
    alu_ctrl_d    = alu_ctrl_q;
    rs_d          = rs_q;
    rt_d          = rt_q;
    rdata1_d      = rdata1_q;
    rdata2_d      = rdata2_q;
    imm_d         = imm_q;
    alusrc_d      = alusrc_q;

    if (id.flush || hz) begin
      ex_valid_d    = 1'b0;
      ex_regwrite_d = 1'b0;
      ex_memread_d  = 1'b0;
      illegal_d     = 1'b0;
    end else begin
      ex_valid_d    = id.id_valid;
      ex_regwrite_d = id.id_valid && id.id_regwrite;
      ex_memread_d  = id.id_valid && id.id_memread;
      illegal_d     = id.id_valid && dec_illegal;
      ex_dest_d     = id.id_regdst ? id.id_rd : id.id_rt;
      alu_ctrl_d    = dec_ctrl;
      rs_d          = id.id_rs;
      rt_d          = id.id_rt;
      rdata1_d      = id.id_rdata1;
      rdata2_d      = id.id_rdata2;
      imm_d         = id.id_imm;
      alusrc_d      = id.id_alusrc;
    end

    // Count stalled instructions even when a flush also squashes them
    if (hz && id.id_valid && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      illegal_q     <= 1'b0;
      ex_dest_q     <= '0;
      stall_cnt_q   <= '0;
      alu_ctrl_q    <= ALU_ADD;
      rs_q          <= '0;
      rt_q          <= '0;
      rdata1_q      <= '0;
      rdata2_q      <= '0;
      imm_q         <= '0;
      alusrc_q      <= 1'b0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_regwrite_q <= ex_regwrite_d;
      ex_memread_q  <= ex_memread_d;
      illegal_q     <= illegal_d;
      ex_dest_q     <= ex_dest_d;
      stall_cnt_q   <= stall_cnt_d;
      alu_ctrl_q    <= alu_ctrl_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      rdata1_q      <= rdata1_d;
      rdata2_q      <= rdata2_d;
      imm_q         <= imm_d;
      alusrc_q      <= alusrc_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_regwrite = ex_regwrite_q;
  assign ex_memread  = ex_memread_q;
  assign illegal     = illegal_q;
  assign ex_dest     = ex_dest_q;
  assign stall_cnt   = stall_cnt_q;
  assign ALU_control = alu_ctrl_q;
  assign Read_data_1 = opa;
  assign Data_2      = alusrc_q ? imm_q : opb;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline register and issue logic that produces the operand and control inputs of the EX-stage ALU: Read_data_1, Data_2 and the 3-bit ALU_control code.
- Latches decoded instructions from ID and decodes ALUOp/funct into ALU_control.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and inserts a bubble on load-use.

Parameters:
- DW, 32, datapath width.
- RW, 5, register index width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_ready  out  1  stage accepts the ID instruction this cycle
- flush  in  1  squash the incoming instruction (branch taken)
- id_rs, id_rt, id_rd  in  RW  source/destination register indices
- id_rdata1, id_rdata2  in  DW  register-file read data
- id_imm  in  DW  sign-extended immediate
- id_alusrc  in  1  1 selects the immediate as Data_2
- id_regdst  in  1  1 selects rd as destination, 0 selects rt
- id_aluop  in  2  main-decoder ALUOp
- id_funct  in  6  R-type funct field
- id_memread, id_regwrite  in  1  load flag and write-back flag
- exm_regwrite  in  1  EX/MEM write-back enable
- exm_rd  in  RW  EX/MEM destination register
- exm_result  in  DW  EX/MEM result
- wb_regwrite  in  1  MEM/WB write-back enable
- wb_rd  in  RW  MEM/WB destination register
- wb_result  in  DW  MEM/WB result
- ex_valid  out  1  EX holds a valid instruction
- Read_data_1  out  DW  ALU operand A
- Data_2  out  DW  ALU operand B
- ALU_control  out  3  0=AND 1=OR 2=ADD 6=SUB 7=SLT
- ex_dest  out  RW  destination register
- ex_regwrite, ex_memread  out  1  registered control flags
- illegal  out  1  undecodable R-type funct in EX
- stall_cnt  out  CNT_W  saturating count of load-use bubbles

Behaviour:
- Reset (async on rst_n=0):
  - ex_valid, ex_regwrite, ex_memread, illegal, ex_dest, stall_cnt and the latched operands all clear to 0.
  - ALU_control resets to 2.
  - Read_data_1 and Data_2 read 0 until the first instruction is latched.
- Hazard: hz = ex_valid & ex_memread & ex_dest!=0 & (ex_dest==id_rs | ex_dest==id_rt).
  - id_ready = !hz (combinational).
- Register update, every clock edge:
  - flush=1: bubble loaded (ex_valid=0, ex_regwrite=0, ex_memread=0). flush has priority over hz.
  - else hz=1: bubble loaded. stall_cnt increments only when id_valid=1, saturating at all-ones with no wrap.
  - else: all id_* fields latched, and ex_valid=id_valid.
  - A bubble (ex_valid=0) always forces ex_regwrite=0 and ex_memread=0.
- ex_dest = id_regdst ? id_rd : id_rt, captured at latch time.
- ALU_control decode, registered:
  - ALUOp 00 gives 2; 01 gives 6; 11 gives 1.
  - ALUOp 10 decodes funct: 100000 gives 2, 100010 gives 6, 100100 gives 0, 100101 gives 1, 101010 gives 7.
  - Any other funct gives 2 with illegal=1. illegal is otherwise 0.
- Forwarding, combinational on the registered rs/rt/rdata:
  - Operand A = exm_result if exm_regwrite & exm_rd!=0 & exm_rd==rs.
  - Otherwise wb_result under the same test against wb_rd.
  - Otherwise the latched rdata1.
  - EX/MEM beats MEM/WB when both match. Register 0 is never forwarded.
- Data_2 = latched alusrc ? latched imm : forwarded rt operand (same rules as A).
- Latency: one cycle from acceptance to EX outputs; no extra latency on the forwarding path.
- Reset mid-bubble clears the state; there is no pending hazard memory.

Optional Feature:
- Macro ALU_FWD_EN.
  - Defined: forwarding behaves as described above.
  - Undefined: operands are the raw latched rdata1 and the rdata2/imm selection.
- With the macro undefined, hz additionally asserts on any match of id_rs/id_rt against:
  - the EX stage (ex_valid & ex_regwrite & ex_dest!=0), and
  - the EX/MEM stage (exm_regwrite & exm_rd!=0).
  - These extra stalls also count in stall_cnt.

Decomposition:
- Shared package holds:
  - the ALU_control codes (ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7);
  - the ALUOp encodings;
  - the funct constants.
- One sub-module, alu_ctrl_dec: combinational ALUOp/funct to ALU_control plus illegal. It is reused by any future multi-cycle variant.

Test Plan:
- ALUOp=10, funct=100010, rdata1=7, rdata2=4, no hazards → next cycle ALU_control=6, Read_data_1=7, Data_2=4, ex_valid=1.
- ALUOp=10, funct=111111 → ALU_control=2, illegal=1. Next instruction with ALUOp=00 → illegal=0.
- EX/MEM writes r3=0x55 and MEM/WB writes r3=0x11, EX rs=3 → Read_data_1=0x55. With exm_regwrite=0 → 0x11. With rd=0 → no forwarding.
- lw r5 in EX followed by add using rt=5 → id_ready=0 for one cycle, bubble inserted (ex_valid=0), stall_cnt 0→1, then the add issues with the forwarded value.
- flush=1 coincident with hz → bubble loaded; stall_cnt still increments only because hz=1 and id_valid=1. Then drive 2^16 stalls → stall_cnt holds at 0xFFFF.
- rst_n pulsed low mid-stream → ex_valid=0 and ALU_control=2 immediately (asynchronous), stall_cnt=0.
